oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 31 +++
 rtl/oam_dma.sv | 136 +++++++++++++
 tb/tb_oam_dma.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
//   Shared definitions for the sprite-memory DMA engine.
//   - Default bus widths.
//   - Trigger and destination register addresses, also used by the CPU/DMA bus
//     mux and the PPU register decode.
//   - FSM state encoding.
//   - Transfer length constants.
// -----------------------------------------------------------------------------
package oam_dma_pkg;

    localparam int DEF_REG_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 16;

    // CPU write here starts a page copy; every copied byte goes to the OAM data port
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    // Bytes per transfer and the CPU stall length (HALT + 256 read/write pairs)
    localparam int XFER_BYTES     = 256;
    localparam int XFER_CYCLES    = 1 + 2 * XFER_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   Copies one 256-byte page of CPU memory to the OAM data port.  A CPU write
//   of page number P to DMA_REG halts the CPU, then the engine alternates
//   READ (bus_addr = {P, idx}) and WRITE (bus_addr = OAM_DATA) for all 256
//   bytes.  If the free-running parity flop is 1 in HALT, one extra ALIGN
//   cycle is inserted before the first read.
//
// Ports
//   clk       : clock, all state on rising edge
//   reset_n   : asynchronous active-low reset
//   cpu_we    : CPU write strobe
//   cpu_addr  : CPU address
//   cpu_din   : CPU write data (source page number)
//   cpu_rdy   : low halts the CPU
//   bus_req   : high while the DMA owns the memory bus
//   bus_addr  : memory bus address
//   bus_we    : memory write enable
//   bus_dout  : memory write data
//   bus_din   : memory read data, combinational from bus_addr
//   busy      : transfer in progress
//   done      : one-cycle pulse in the first IDLE cycle after a transfer
// -----------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int                    WIDTH      = DEF_REG_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG    = ADDR_WIDTH'(DMA_REG_ADDR),
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA   = ADDR_WIDTH'(OAM_DATA_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_din,
    output logic                  cpu_rdy,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_we,
    output logic [WIDTH-1:0]      bus_dout,
    input  logic [WIDTH-1:0]      bus_din,
    output logic                  busy,
    output logic                  done
);

    dma_state_e       state;
    logic [WIDTH-1:0] page;
    logic [7:0]       idx;
    logic [WIDTH-1:0] data;
    logic             parity;

    wire trigger = cpu_we && (cpu_addr == DMA_REG);

    // Free-running cycle parity; decides whether the first read needs an
    // alignment cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity <= 1'b0;
        else          parity <= ~parity;
    end

    // Control FSM.  busy / bus_req / cpu_rdy / done are registered alongside
    // the state so they change only on the transitions into and out of IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            page    <= '0;
            idx     <= '0;
            data    <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            bus_req <= 1'b0;
            cpu_rdy <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page    <= cpu_din;
                        idx     <= 8'h00;
                        state   <= HALT;
                        busy    <= 1'b1;
                        bus_req <= 1'b1;
                        cpu_rdy <= 1'b0;
                    end
                end
                HALT:  state <= parity ? ALIGN : READ;
                ALIGN: state <= READ;
                READ: begin
                    data  <= bus_din;
                    state <= WRITE;
                end
                WRITE: begin
                    // 8-bit counter: wraps FF->00 on the last byte, so page
                    // never advances into the next one.
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                        cpu_rdy <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                    cpu_rdy <= 1'b1;
                end
            endcase
        end
    end

    // Bus side is a pure decode of registered state; nothing from cpu_*
    // reaches it in the same cycle.
    always_comb begin
        bus_addr = '0;
        bus_we   = 1'b0;
        bus_dout = '0;
        case (state)
            READ: begin
                bus_addr = ADDR_WIDTH'({page, idx});
            end
            WRITE: begin
                bus_addr = OAM_DATA;
                bus_we   = 1'b1;
                bus_dout = data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Scoreboard bench.  The driver issues triggers and pushes the expected
//   (source address, byte) stream and the expected stall length; a monitor on
//   the falling edge pops and compares every OAM write and every CPU release.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        bus_req;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q [$];
    int          len_q [$];

    int          tests = 0;
    int          fails = 0;
    int          low_cnt = 0;
    int          tb_cnt;
    logic [15:0] prev_addr = '0;
    logic        end_req = 1'b0;
    logic        fin_ack = 1'b0;

    always #5 clk = ~clk;

    assign bus_din = mem[bus_addr];

    oam_dma dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_rdy  (cpu_rdy),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .busy     (busy),
        .done     (done)
    );

    // Clock edges seen since reset release; its LSB is the cycle parity.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 0;
        else          tb_cnt <= tb_cnt + 1;
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_cpu_rdy", cpu_rdy, 1);
            chk("rst_bus_req", bus_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_bus_we", bus_we, 0);
            chk("rst_bus_addr", bus_addr, 0);
            chk("rst_bus_dout", bus_dout, 0);
            exp_q.delete();
            len_q.delete();
            low_cnt = 0;
        end else if (end_req && !fin_ack) begin
            chk("end_exp_q_empty", exp_q.size(), 0);
            chk("end_len_q_empty", len_q.size(), 0);
            chk("end_cpu_rdy", cpu_rdy, 1);
            fin_ack = 1'b1;
        end else begin
            chk("busy_vs_rdy", busy, !cpu_rdy);
            chk("bus_req_vs_rdy", bus_req, !cpu_rdy);
            if (!cpu_rdy) begin
                low_cnt++;
                chk("done_while_busy", done, 0);
            end else begin
                chk("done_pulse", done, (low_cnt > 0));
                if (low_cnt > 0) begin
                    if (len_q.size() == 0) chk("unexpected_stall", low_cnt, 0);
                    else                   chk("stall_cycles", low_cnt, len_q.pop_front());
                    low_cnt = 0;
                end
                chk("idle_bus_we", bus_we, 0);
                chk("idle_bus_addr", bus_addr, 0);
            end
            if (bus_we) begin
                chk("wr_addr", bus_addr, 16'h2004);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_addr", prev_addr, e.addr);
                    chk("wr_data", bus_dout, e.data);
                end
            end
            prev_addr = bus_addr;
        end
    end

    // ---------------- driver ----------------
    // par: 0/1 forces the parity seen in HALT, 2 = whatever it is now.
    task automatic trigger(input logic [7:0] pg, input int par);
        logic [15:0] a;
        if (par != 2 && ((tb_cnt + 1) % 2) != par) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            a = {pg, 8'(i)};
            exp_q.push_back('{a, mem[a]});
        end
        len_q.push_back(513 + ((tb_cnt + 1) % 2));
        cpu_we   = 1'b1;
        cpu_addr = 16'h4014;
        cpu_din  = pg;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 16'($urandom);
        cpu_din  = 8'($urandom);
    endtask

    // Returns at the falling edge where done is high.
    task automatic wait_done();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done) return;
        end
        $display("FAIL wait_done: no done pulse within 1000 cycles");
        $fatal(1, "timeout");
    endtask

    initial begin
        logic [7:0] pg;
        reset_n  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++)   mem[16'h0300 + i] = 8'(i) ^ 8'hA5;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // page 02, parity 0 then parity 1
        trigger(8'h02, 0); wait_done();
        trigger(8'h02, 1); wait_done();

        // page 03 preloaded with i^A5
        trigger(8'h03, 2); wait_done();

        // re-trigger while busy must be ignored
        trigger(8'h02, 2);
        repeat (100) @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_din = 8'h07;
        @(negedge clk);
        cpu_we = 1'b0;
        wait_done();

        // top page, then a new trigger accepted in the done cycle
        trigger(8'hFF, 2); wait_done();
        trigger(8'($urandom), 2); wait_done();

        // non-matching address, read of DMA_REG, neighbour address
        repeat (2) @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_din = 8'h02;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h4014;
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'h4013;
        @(negedge clk);
        cpu_we = 1'b0;
        repeat (20) @(negedge clk);

        // reset during WRITE of idx 40
        pg = 8'($urandom);
        trigger(pg, 2);
        begin
            bit hit = 1'b0;
            for (int n = 0; n < 1000 && !hit; n++) begin
                @(negedge clk);
                if (bus_req && !bus_we && bus_addr == {pg, 8'h40}) hit = 1'b1;
            end
            if (!hit) begin
                $display("FAIL abort_wait: idx 40 read never seen");
                $fatal(1, "timeout");
            end
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        trigger(8'h02, 2); wait_done();

        // a few random pages
        for (int k = 0; k < 2; k++) begin
            trigger(8'($urandom), 2); wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        end_req = 1'b1;
        for (int n = 0; n < 10 && !fin_ack; n++) @(negedge clk);
        @(negedge clk);
        if (!fin_ack) begin
            $display("FAIL final_check: monitor did not complete");
            $fatal(1, "timeout");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
